// File: rtl/store_write_buffer.sv
// store_write_buffer: write-through store queue draining data-cache stores to memory.
// Stores from the MEM stage are queued in a circular FIFO. The head entry is offered
// to the shared memory port whenever the miss bridge grants the port. A block-address
// compare against the pending fill address flags read-after-write hazards.
// Optional feature: define STORE_COALESCE_EN to merge a store into the newest entry
// when the addresses match.
module store_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              wb_full,
    output logic              wb_empty,
    output logic [CNT_W-1:0]  wb_count,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_wr_grant,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_conflict,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               coalesce;
    logic               push;
    logic               pop;
    logic               unused_chk_low;

    assign unused_chk_low = ^chk_addr[3:0];

    // Full/empty are decoded from the registered count, so a same-cycle pop never frees a slot early
    assign wb_full      = (count_q == CNT_W'(DEPTH));
    assign wb_empty     = (count_q == '0);
    assign wb_count     = count_q;
    assign mem_write_en = (state_q == REQ);
    assign mem_addr_out = addr_q[rd_ptr_q];
    assign mem_data_out = data_q[rd_ptr_q];
    assign overflow_err = overflow_q;
    assign flush_done   = flush_req && wb_empty && (state_q == IDLE);
    assign tail_ptr     = wr_ptr_q - PTR_W'(1);

    // Merge into the newest entry unless that entry is the head already being offered
`ifdef STORE_COALESCE_EN
    assign coalesce = st_valid && !wb_empty && (addr_q[tail_ptr] == st_addr)
                      && !((count_q == CNT_W'(1)) && (state_q == REQ));
`else
    assign coalesce = 1'b0;
`endif

    assign push = st_valid && !coalesce && !wb_full;
    assign pop  = (state_q == REQ) && mem_wr_grant;

    // Block-granular hazard check against every queued store, head included
    always_comb begin
        chk_conflict = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_W-1:4] == chk_addr[ADDR_W-1:4])) begin
                chk_conflict = 1'b1;
            end
        end
    end

    // Drain FSM next state: request while entries remain, pop on grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!wb_empty) state_d = REQ;
            end
            REQ: begin
                if (mem_wr_grant) state_d = (count_q > CNT_W'(1)) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer, occupancy and sticky-error next state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        if (st_valid && wb_full && !coalesce) overflow_d = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage: allocate at tail, merge into tail, retire at head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) valid_q[rd_ptr_q] <= 1'b0;
            if (push) begin
                addr_q[wr_ptr_q]  <= st_addr;
                data_q[wr_ptr_q]  <= st_data;
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (coalesce) data_q[tail_ptr] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: scoreboard bench for store_write_buffer (DEPTH=4, 16-bit).
// Expected memory writes are queued when stores are driven and compared as the
// DUT presents granted writes.
module tb_store_write_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        wb_full;
    logic        wb_empty;
    logic [2:0]  wb_count;
    logic        mem_write_en;
    logic [15:0] mem_addr_out;
    logic [15:0] mem_data_out;
    logic        mem_wr_grant;
    logic [15:0] chk_addr;
    logic        chk_conflict;
    logic        flush_req;
    logic        flush_done;
    logic        overflow_err;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    store_write_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .wb_full      (wb_full),
        .wb_empty     (wb_empty),
        .wb_count     (wb_count),
        .mem_write_en (mem_write_en),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_wr_grant (mem_wr_grant),
        .chk_addr     (chk_addr),
        .chk_conflict (chk_conflict),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One store, captured at the next edge; also records the expected write
    task automatic push(input logic [15:0] a, input logic [15:0] d, input bit expect_write);
        ent_t e;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        if (expect_write) begin
            e.a = a;
            e.d = d;
            sb.push_back(e);
        end
        step();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        mem_wr_grant = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (wb_empty && !mem_write_en) break;
            step();
        end
        mem_wr_grant = 1'b0;
        check("drain_empty", wb_empty, 1'b1);
    endtask

    // Compare each granted write against the oldest expected store
    always @(negedge clk) begin
        if (rst && mem_write_en && mem_wr_grant) begin
            check("sb_nonempty", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
                ent_t e;
                e = sb.pop_front();
                check("wr_addr", mem_addr_out, e.a);
                check("wr_data", mem_data_out, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        st_valid     = 1'b0;
        st_addr      = '0;
        st_data      = '0;
        mem_wr_grant = 1'b0;
        chk_addr     = 16'hFFF0;
        flush_req    = 1'b0;

        // Reset state
        #23;
        check("rst_empty", wb_empty, 1'b1);
        check("rst_count", wb_count, 3'd0);
        check("rst_wen", mem_write_en, 1'b0);
        check("rst_full", wb_full, 1'b0);
        check("rst_ovf", overflow_err, 1'b0);
        check("rst_addr", mem_addr_out, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_empty", wb_empty, 1'b1);
        check("post_rst_wen", mem_write_en, 1'b0);
        check("post_rst_conf", chk_conflict, 1'b0);

        // Single store with grant tied high
        mem_wr_grant = 1'b1;
        push(16'h0010, 16'hBEEF, 1'b1);
        check("single_count", wb_count, 3'd1);
        check("single_empty", wb_empty, 1'b0);
        check("single_wen_early", mem_write_en, 1'b0);
        step();
        check("single_wen", mem_write_en, 1'b1);
        check("single_addr", mem_addr_out, 16'h0010);
        check("single_data", mem_data_out, 16'hBEEF);
        step();
        check("single_done_empty", wb_empty, 1'b1);
        check("single_done_wen", mem_write_en, 1'b0);
        mem_wr_grant = 1'b0;

        // Fill to full, overflow, then drain in order
        push(16'h0000, 16'hA000, 1'b1);
        push(16'h0002, 16'hA002, 1'b1);
        push(16'h0004, 16'hA004, 1'b1);
        push(16'h0006, 16'hA006, 1'b1);
        check("fill_full", wb_full, 1'b1);
        check("fill_count", wb_count, 3'd4);
        check("fill_ovf_clear", overflow_err, 1'b0);
        push(16'h0008, 16'hA008, 1'b0);
        check("ovf_set", overflow_err, 1'b1);
        check("ovf_count", wb_count, 3'd4);
        flush_req = 1'b1;
        #1;
        check("flush_busy", flush_done, 1'b0);
        drain();
        #1;
        check("flush_done", flush_done, 1'b1);
        check("ovf_sticky", overflow_err, 1'b1);
        flush_req = 1'b0;

        // Block-address conflict
        push(16'h0024, 16'h1234, 1'b1);
        chk_addr = 16'h0020;
        #1;
        check("conf_hit", chk_conflict, 1'b1);
        chk_addr = 16'h0030;
        #1;
        check("conf_miss", chk_conflict, 1'b0);
        chk_addr = 16'h0020;
        drain();
        #1;
        check("conf_cleared", chk_conflict, 1'b0);
        chk_addr = 16'hFFF0;

        // Head held stable without grant, then push+pop at count 2
        push(16'h0100, 16'h000A, 1'b1);
        push(16'h0102, 16'h000B, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_wen", mem_write_en, 1'b1);
            check("hold_addr", mem_addr_out, 16'h0100);
            check("hold_data", mem_data_out, 16'h000A);
            step();
        end
        mem_wr_grant = 1'b1;
        push(16'h0104, 16'h000C, 1'b1);
        mem_wr_grant = 1'b0;
        check("pp_count", wb_count, 3'd2);
        check("pp_head", mem_addr_out, 16'h0102);
        drain();

        // Coalescing into the tail (head already in REQ is never modified)
        push(16'h0040, 16'h1111, 1'b1);
        step();
        check("co_req", mem_write_en, 1'b1);
        push(16'h0040, 16'h2222, 1'b1);
`ifdef STORE_COALESCE_EN
        push(16'h0040, 16'h3333, 1'b0);
        sb[sb.size()-1].d = 16'h3333;
        check("co_count", wb_count, 3'd2);
`else
        push(16'h0040, 16'h3333, 1'b1);
        check("co_count", wb_count, 3'd3);
`endif
        drain();

        repeat (2) step();
        check("sb_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
